// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - parametrised register file with two registered read ports and a busy scoreboard (optional macro: REGFILE_WRITE_BYPASS_EN)
module regfile_scoreboard #(
    parameter int            N         = 16,
    parameter int            ADDR_W    = 3,
    parameter logic [N-1:0]  RESET_VAL = '0,
    parameter int            ZERO_REG  = 0,
    localparam int           DEPTH     = 1 << ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              read_enable,
    input  logic [ADDR_W-1:0] read_addr1,
    input  logic [ADDR_W-1:0] read_addr2,
    output logic [N-1:0]      read_data1,
    output logic [N-1:0]      read_data2,
    output logic              read_busy1,
    output logic              read_busy2,
    input  logic              write_enable,
    input  logic [ADDR_W-1:0] write_addr,
    input  logic [N-1:0]      write_data,
    input  logic              reserve_enable,
    input  logic [ADDR_W-1:0] reserve_addr,
    output logic              reserve_conflict,
    output logic [DEPTH-1:0]  busy_vec
);

    logic [N-1:0]      regs [DEPTH];
    logic [DEPTH-1:0]  busy_q;
    logic [DEPTH-1:0]  busy_n;
    logic              wr_ok;
    logic              rs_ok;
    logic              conflict_n;
    logic [ADDR_W-1:0] raddr   [2];
    logic [N-1:0]      rdata_n [2];
    logic              rbusy_n [2];

    // Register 0 swallows writes and reserves when it is hardwired to zero
    assign wr_ok = write_enable   && !((ZERO_REG != 0) && (write_addr   == '0));
    assign rs_ok = reserve_enable && !((ZERO_REG != 0) && (reserve_addr == '0));

    assign raddr[0] = read_addr1;
    assign raddr[1] = read_addr2;
    assign busy_vec = busy_q;

    // Next scoreboard: retirement clears first, then a new producer sets, so same-address reserve wins
    always_comb begin
        busy_n = busy_q;
        if (wr_ok) begin
            busy_n[write_addr] = 1'b0;
        end
        if (rs_ok) begin
            busy_n[reserve_addr] = 1'b1;
        end
    end

    // A conflict is a reserve on a busy register whose producer is not retiring this cycle
    always_comb begin
        conflict_n = rs_ok && busy_q[reserve_addr] && !(wr_ok && (write_addr == reserve_addr));
    end

    // Read-port selection for both ports, with optional write-through of same-cycle writes
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rdata_n[p] = regs[raddr[p]];
            rbusy_n[p] = busy_q[raddr[p]];
`ifdef REGFILE_WRITE_BYPASS_EN
            if (wr_ok && (raddr[p] == write_addr)) begin
                rdata_n[p] = write_data;
                rbusy_n[p] = busy_n[write_addr];
            end
`endif
            if ((ZERO_REG != 0) && (raddr[p] == '0)) begin
                rdata_n[p] = '0;
                rbusy_n[p] = 1'b0;
            end
        end
    end

    // Register array storage
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= RESET_VAL;
            end
        end else if (wr_ok) begin
            regs[write_addr] <= write_data;
        end
    end

    // Scoreboard flops and the one-cycle conflict pulse
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_q           <= '0;
            reserve_conflict <= 1'b0;
        end else begin
            busy_q           <= busy_n;
            reserve_conflict <= conflict_n;
        end
    end

    // Registered read outputs, held while read_enable is low
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            read_data1 <= '0;
            read_data2 <= '0;
            read_busy1 <= 1'b0;
            read_busy2 <= 1'b0;
        end else if (read_enable) begin
            read_data1 <= rdata_n[0];
            read_data2 <= rdata_n[1];
            read_busy1 <= rbusy_n[0];
            read_busy2 <= rbusy_n[1];
        end
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb/tb_regfile_scoreboard.sv - randomized bench for regfile_scoreboard against a behavioural model
module tb_regfile_scoreboard;

`ifdef REGFILE_WRITE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif
    localparam logic [15:0] RV = 16'h00A5;

    logic        clk;
    logic        rst;
    logic        re;
    logic [2:0]  a1, a2;
    logic        we;
    logic [2:0]  wa;
    logic [15:0] wd;
    logic        rs;
    logic [2:0]  ra;

    logic [15:0] rd1 [2];
    logic [15:0] rd2 [2];
    logic        rb1 [2];
    logic        rb2 [2];
    logic        conf [2];
    logic [7:0]  bv [2];

    int n_checks = 0;
    int n_pass   = 0;

    // model state; index 0 = plain instance, 1 = ZERO_REG instance
    logic [15:0] m_mem  [2][8];
    bit          m_busy [2][8];
    logic [15:0] e_rd1 [2], e_rd2 [2];
    bit          e_rb1 [2], e_rb2 [2], e_conf [2];

    regfile_scoreboard #(.N(16), .ADDR_W(3), .RESET_VAL(RV), .ZERO_REG(0)) u_dut0 (
        .clk(clk), .rst(rst), .read_enable(re), .read_addr1(a1), .read_addr2(a2),
        .read_data1(rd1[0]), .read_data2(rd2[0]), .read_busy1(rb1[0]), .read_busy2(rb2[0]),
        .write_enable(we), .write_addr(wa), .write_data(wd),
        .reserve_enable(rs), .reserve_addr(ra), .reserve_conflict(conf[0]), .busy_vec(bv[0])
    );

    regfile_scoreboard #(.N(16), .ADDR_W(3), .RESET_VAL(RV), .ZERO_REG(1)) u_dut1 (
        .clk(clk), .rst(rst), .read_enable(re), .read_addr1(a1), .read_addr2(a2),
        .read_data1(rd1[1]), .read_data2(rd2[1]), .read_busy1(rb1[1]), .read_busy2(rb2[1]),
        .write_enable(we), .write_addr(wa), .write_data(wd),
        .reserve_enable(rs), .reserve_addr(ra), .reserve_conflict(conf[1]), .busy_vec(bv[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [7:0] model_vec(input int k);
        logic [7:0] v = '0;
        for (int i = 0; i < 8; i++) v[i] = m_busy[k][i];
        return v;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 8; i++) begin
                m_mem[k][i]  = RV;
                m_busy[k][i] = 1'b0;
            end
            e_rd1[k] = '0; e_rd2[k] = '0;
            e_rb1[k] = 0;  e_rb2[k] = 0; e_conf[k] = 0;
        end
    endtask

    // what a read port returns for address a, given this cycle's write/reserve
    task automatic model_read(input int k, input logic [2:0] a, input bit wv, input bit rv,
                              output logic [15:0] d, output bit b);
        if (k == 1 && a == 3'd0) begin
            d = '0; b = 0;
        end else if (BYP && wv && a == wa) begin
            d = wd; b = rv && (ra == wa);
        end else begin
            d = m_mem[k][a]; b = m_busy[k][a];
        end
    endtask

    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            bit wv, rv;
            wv = we && !(k == 1 && wa == 3'd0);
            rv = rs && !(k == 1 && ra == 3'd0);
            if (re) begin
                model_read(k, a1, wv, rv, e_rd1[k], e_rb1[k]);
                model_read(k, a2, wv, rv, e_rd2[k], e_rb2[k]);
            end
            e_conf[k] = rv && m_busy[k][ra] && !(wv && wa == ra);
            if (wv) begin
                m_mem[k][wa]  = wd;
                m_busy[k][wa] = 1'b0;
            end
            if (rv) m_busy[k][ra] = 1'b1;
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < 2; k++) begin
            check($sformatf("rd1[%0d]", k), 32'(rd1[k]), 32'(e_rd1[k]));
            check($sformatf("rd2[%0d]", k), 32'(rd2[k]), 32'(e_rd2[k]));
            check($sformatf("rb1[%0d]", k), 32'(rb1[k]), 32'(e_rb1[k]));
            check($sformatf("rb2[%0d]", k), 32'(rb2[k]), 32'(e_rb2[k]));
            check($sformatf("conf[%0d]", k), 32'(conf[k]), 32'(e_conf[k]));
            check($sformatf("busy_vec[%0d]", k), 32'(bv[k]), 32'(model_vec(k)));
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        for (int k = 0; k < 2; k++) begin
            check({tag, "_rd1"}, 32'(rd1[k]), 32'h0);
            check({tag, "_rd2"}, 32'(rd2[k]), 32'h0);
            check({tag, "_rb"},  32'({rb1[k], rb2[k]}), 32'h0);
            check({tag, "_conf"}, 32'(conf[k]), 32'h0);
            check({tag, "_bv"},  32'(bv[k]), 32'h0);
        end
    endtask

    task automatic cycle(input bit i_re, input logic [2:0] i_a1, input logic [2:0] i_a2,
                         input bit i_we, input logic [2:0] i_wa, input logic [15:0] i_wd,
                         input bit i_rs, input logic [2:0] i_ra);
        re = i_re; a1 = i_a1; a2 = i_a2;
        we = i_we; wa = i_wa; wd = i_wd;
        rs = i_rs; ra = i_ra;
        @(posedge clk);
        #1;
        model_step();
        check_all();
    endtask

    task automatic idle();
        cycle(0, 0, 0, 0, 0, 16'h0, 0, 0);
    endtask

    initial begin
        rst = 1'b0;
        re = 0; a1 = 0; a2 = 0; we = 0; wa = 0; wd = 0; rs = 0; ra = 0;
        model_reset();
        #1;
        check_reset_outputs("rst_hold0");
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("rst_hold2");
        rst = 1'b1;

        // every register reads its reset value
        for (int a = 0; a < 8; a++) begin
            cycle(1, 3'(a), 3'(7 - a), 0, 0, 16'h0, 0, 0);
            check("rst_val", 32'(rd1[0]), 32'(RV));
        end

        // write then dual-port read of the same address
        cycle(0, 0, 0, 1, 3'd3, 16'h1234, 0, 0);
        cycle(1, 3'd3, 3'd3, 0, 0, 16'h0, 0, 0);
        check("r3_p1", 32'(rd1[0]), 32'h1234);
        check("r3_p2", 32'(rd2[0]), 32'h1234);

        // reserve / read / writeback / read
        cycle(0, 0, 0, 0, 0, 16'h0, 1, 3'd5);
        check("bv5_set", 32'(bv[0][5]), 32'h1);
        cycle(1, 3'd5, 3'd0, 0, 0, 16'h0, 0, 0);
        check("r5_busy", 32'(rb1[0]), 32'h1);
        cycle(0, 0, 0, 1, 3'd5, 16'hBEEF, 0, 0);
        check("bv5_clr", 32'(bv[0][5]), 32'h0);
        cycle(1, 3'd5, 3'd5, 0, 0, 16'h0, 0, 0);
        check("r5_data", 32'(rd1[0]), 32'hBEEF);
        check("r5_nbusy", 32'(rb1[0]), 32'h0);

        // double reserve conflicts; write+reserve same cycle does not
        cycle(0, 0, 0, 0, 0, 16'h0, 1, 3'd2);
        check("conf_first", 32'(conf[0]), 32'h0);
        cycle(0, 0, 0, 0, 0, 16'h0, 1, 3'd2);
        check("conf_second", 32'(conf[0]), 32'h1);
        idle();
        check("conf_pulse", 32'(conf[0]), 32'h0);
        cycle(0, 0, 0, 1, 3'd2, 16'h2222, 1, 3'd2);
        check("conf_wr_rs", 32'(conf[0]), 32'h0);
        check("bv2_wr_rs", 32'(bv[0][2]), 32'h1);

        // same-cycle write and read of r4
        cycle(0, 0, 0, 1, 3'd4, 16'h0000, 0, 0);
        cycle(1, 3'd4, 3'd1, 1, 3'd4, 16'h0F0F, 0, 0);
        check("r4_bypass", 32'(rd1[0]), BYP ? 32'h0F0F : 32'h0000);

        // hardwired zero register ignores writes and reserves
        cycle(0, 0, 0, 1, 3'd0, 16'hFFFF, 1, 3'd0);
        cycle(1, 3'd0, 3'd0, 0, 0, 16'h0, 1, 3'd0);
        check("zr_data", 32'(rd1[1]), 32'h0);
        check("zr_busy", 32'(rb1[1]), 32'h0);
        check("zr_conf", 32'(conf[1]), 32'h0);
        check("zr_bv0", 32'(bv[1][0]), 32'h0);
        check("nz_r0_data", 32'(rd1[0]), 32'hFFFF);

        // randomized traffic with occasional mid-run reset
        for (int t = 0; t < 600; t++) begin
            if ($urandom_range(0, 79) == 0) begin
                rst = 1'b0;
                #1;
                model_reset();
                check_reset_outputs("rst_async");
                @(posedge clk);
                #1;
                check_reset_outputs("rst_mid");
                rst = 1'b1;
            end else begin
                cycle($urandom_range(0, 3) != 0, 3'($urandom), 3'($urandom),
                      $urandom_range(0, 1) == 1, 3'($urandom), 16'($urandom),
                      $urandom_range(0, 2) == 0, 3'($urandom_range(0, 3)));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
